// File: rtl/c_drain.sv
// Result-matrix drain: snapshots the four C entries on start, then streams them
// out over valid/ready with storage-address tags so C storage can be reused.
module c_drain #(
  parameter int width     = 32,
  parameter int COL_MAJOR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] c1,
  input  logic [width-1:0] c2,
  input  logic [width-1:0] c3,
  input  logic [width-1:0] c4,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [width-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [3:0][width-1:0]       buf_q, buf_d;
  logic                        ovr_q, ovr_d;
  logic [3:0][width-1:0]       c_in;
  logic [1:0]                  idx_w;
  logic                        send_w;

  assign c_in = {c4, c3, c2, c1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_SEND: begin
        // A start mid-frame is dropped; the snapshot belongs to the frame in flight.
        if (start) ovr_d = 1'b1;
        if (out_ready) begin
          if (cnt_q == 2'd3) state_d = S_DONE;
          else               cnt_d   = cnt_q + 2'd1;
        end
      end
      default: begin
        if (start) begin
          buf_d   = c_in;
          cnt_d   = 2'd0;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      ovr_q   <= ovr_d;
    end
  end

  // Column-major order 0,2,1,3 is just the counter with its bits swapped.
  assign idx_w  = (COL_MAJOR != 0) ? {cnt_q[0], cnt_q[1]} : cnt_q;
  assign send_w = (state_q == S_SEND);

  always_comb begin
    out_valid = send_w;
    out_idx   = send_w ? idx_w : 2'd0;
    out_data  = send_w ? buf_q[idx_w] : '0;
    out_last  = send_w && (cnt_q == 2'd3);
    busy      = send_w;
    done      = (state_q == S_DONE);
    overrun   = ovr_q;
  end

endmodule

// File: tb/tb_c_drain.sv
// Drives a row-major and a column-major c_drain from the same stimulus and
// compares both every cycle against a queue-based frame model.
module tb_c_drain;
  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [31:0] c1, c2, c3, c4;

  logic        v0, l0, b0, dn0, ov0, v1, l1, b1, dn1, ov1;
  logic [31:0] d0, d1;
  logic [1:0]  i0, i1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_drain #(.width(32), .COL_MAJOR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .out_ready(out_ready), .out_valid(v0), .out_data(d0), .out_idx(i0),
    .out_last(l0), .busy(b0), .done(dn0), .overrun(ov0));

  c_drain #(.width(32), .COL_MAJOR(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .out_ready(out_ready), .out_valid(v1), .out_data(d1), .out_idx(i1),
    .out_last(l1), .busy(b1), .done(dn1), .overrun(ov1));

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [31:0] d; logic [1:0] i; } w_t;
  w_t   q0[$];
  w_t   q1[$];
  logic m_done = 1'b0;
  logic m_ovr  = 1'b0;

  always @(posedge clk or posedge reset) begin
    int ord0 [4];
    int ord1 [4];
    logic [31:0] cv [4];
    ord0 = '{0, 1, 2, 3};
    ord1 = '{0, 2, 1, 3};
    cv   = '{c1, c2, c3, c4};
    if (reset) begin
      q0.delete(); q1.delete();
      m_done = 1'b0;
      m_ovr  = 1'b0;
    end else if (q0.size() > 0) begin
      m_done = 1'b0;
      if (start) m_ovr = 1'b1;
      if (out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (q0.size() == 0) m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start)
        for (int k = 0; k < 4; k++) begin
          q0.push_back('{d: cv[ord0[k]], i: 2'(ord0[k])});
          q1.push_back('{d: cv[ord1[k]], i: 2'(ord1[k])});
        end
    end
  end

  // Packed view: {valid, data, idx, last, busy, done, overrun}
  function automatic logic [38:0] expect_of(input w_t head, input int sz);
    logic v;
    v = (sz > 0);
    return {v, v ? head.d : 32'h0, v ? head.i : 2'd0, v && (sz == 1), v, m_done, m_ovr};
  endfunction

  always @(negedge clk) begin
    w_t h0, h1;
    logic [38:0] e0, e1, a0, a1;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    e0 = expect_of(h0, q0.size());
    e1 = expect_of(h1, q1.size());
    a0 = {v0, d0, i0, l0, b0, dn0, ov0};
    a1 = {v1, d1, i1, l1, b1, dn1, ov1};
    checks += 2;
    if (a0 !== e0) begin
      errors++;
      $display("FAIL model_row t=%0t got %h want %h", $time, a0, e0);
    end
    if (a1 !== e1) begin
      errors++;
      $display("FAIL model_col t=%0t got %h want %h", $time, a1, e1);
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic setc(input logic [31:0] a, b, c, d);
    c1 = a; c2 = b; c3 = c; c4 = d;
  endtask

  logic pat [12];

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    setc(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", d0, 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_ovr", 32'(ov0), 0);
    reset = 1'b0;
    @(negedge clk);

    // Frame A, ready held high: N+1..N+4 words, done in N+5
    setc(32'h11, 32'h22, 32'h33, 32'h44);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("a0_row_data", d0, 32'h11); chk("a0_busy", 32'(b0), 1);
    chk("a0_col_data", d1, 32'h11); chk("a0_last", 32'(l0), 0);
    @(negedge clk);
    chk("a1_row_data", d0, 32'h22); chk("a1_col_data", d1, 32'h33);
    chk("a1_col_idx", 32'(i1), 2);
    @(negedge clk);
    chk("a2_row_data", d0, 32'h33); chk("a2_col_data", d1, 32'h22);
    chk("a2_col_idx", 32'(i1), 1);
    @(negedge clk);
    chk("a3_row_data", d0, 32'h44); chk("a3_last", 32'(l0), 1);
    chk("a3_row_idx", 32'(i0), 3);
    @(negedge clk);
    chk("a_done", 32'(dn0), 1); chk("a_done_valid", 32'(v0), 0);

    // Frame B starts in the done cycle
    setc(32'h55, 32'h66, 32'h77, 32'h88);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("b_first", d0, 32'h55); chk("b_ovr", 32'(ov0), 0);
    chk("b_not_done", 32'(dn0), 0);
    repeat (6) @(negedge clk);

    // Frame C: inputs change after capture, mid-frame start -> overrun
    setc(32'h11, 32'h22, 32'h33, 32'h44);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    setc(32'hAA, 32'hAB, 32'hAC, 32'hAD);
    @(negedge clk); start = 1'b1;
    chk("c_word2", d0, 32'h22);
    @(negedge clk); start = 1'b0;
    chk("c_word3", d0, 32'h33);
    repeat (4) @(negedge clk);
    chk("c_ovr_sticky", 32'(ov0), 1);

    // Frame D: ready toggling
    pat = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
    setc(32'h1, 32'h2, 32'h3, 32'h4);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      out_ready = pat[k];
      @(negedge clk);
    end
    chk("d_idle", 32'(v0), 0);

    // Reset during the 2nd word
    out_ready = 1'b1;
    setc(32'h9, 32'h8, 32'h7, 32'h6);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("r_word2", d0, 32'h8);
    reset = 1'b1;
    #1;
    chk("r_valid", 32'(v0), 0); chk("r_data", d0, 0);
    chk("r_ovr", 32'(ov0), 0); chk("r_busy", 32'(b1), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("r_no_done", 32'(dn0), 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("r_clean_first", d0, 32'h9);
    repeat (5) @(negedge clk);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start     = ($urandom % 4) == 0;
      out_ready = ($urandom % 3) != 0;
      reset     = ($urandom % 150) == 0;
      setc($urandom, $urandom, $urandom, $urandom);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
